vga_scanout: RTL and testbench

Display scan-out stage between the frame-buffer reader (DDR-backed pixel stream) and the board VGA DAC pins. Generates 640x480@60 raster timing from a 50 MHz clock with a 2:1 pixel enable. Pops one 24-bit pixel per active pixel slot from a valid/ready stream. Handles frame alignment via a start-of-frame marker, and substitutes a fill colour with sticky error reporting on stream underflow.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/vga_scanout.sv | 156 +++++++++++++++
 tb/tb_vga_scanout.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan-out slice.
package vga_pkg;

  // Default raster timing, in pixels (horizontal) and lines (vertical).
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic [23:0] FILL_RGB_DEF = 24'hFF00FF;

  // Raster counter width; covers both 800 and 525 with margin.
  localparam int CNT_W = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    RESYNC = 1'b0,
    RUN    = 1'b1
  } scan_state_t;

  // Increment that sticks at a ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic [15:0] max);
    return (val >= max) ? max : val + 16'd1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable phase, raster counters and region decode for the scan-out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  output logic phase,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Phase toggles every clock; counters step only on the phase==1 advance cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // Region decode of the slot currently addressed by the counters.
  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_n   = !((h_cnt >= H_SS) && (h_cnt < H_SE));
    vs_n   = !((v_cnt >= V_SS) && (v_cnt < V_SE));
    origin = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: pops one stream pixel per active slot, aligns frames on
// pix_sof, fills and counts on underflow, and registers all DAC outputs.
//
// Stream handshake: a pixel transfers on a clock where pix_valid and
// pix_ready are both high. pix_ready is combinational and is only raised on
// advance cycles where this block actually consumes the head pixel; pix_data
// and pix_sof are sampled in that same cycle.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          H_FP     = H_FP_DEF,
  parameter int          H_SYNC   = H_SYNC_DEF,
  parameter int          H_BP     = H_BP_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          V_FP     = V_FP_DEF,
  parameter int          V_SYNC   = V_SYNC_DEF,
  parameter int          V_BP     = V_BP_DEF,
  parameter logic [23:0] FILL_RGB = FILL_RGB_DEF,
  parameter logic [15:0] CNT_MAX  = 16'hFFFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [23:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        err_clr,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic        vga_sync,
  output logic        vga_vga_clk,
  output scan_state_t dbg_state
);

  logic        phase;
  logic        active;
  logic        hs_n;
  logic        vs_n;
  logic        origin;

  scan_state_t state;
  logic        pop;
  logic        uf_event;
  logic        goto_run;
  logic        goto_resync;
  rgb_t        rgb_nxt;
  rgb_t        rgb_q;
  logic        head_sof;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .phase         (phase),
    .active        (active),
    .hs_n          (hs_n),
    .vs_n          (vs_n),
    .origin        (origin)
  );

  assign head_sof = pix_valid & pix_sof;

  // Per-slot decision: what to pop, what colour to show and where the FSM goes.
  always_comb begin
    pop         = 1'b0;
    uf_event    = 1'b0;
    goto_run    = 1'b0;
    goto_resync = 1'b0;
    rgb_nxt     = active ? rgb_t'(FILL_RGB) : rgb_t'(24'h0);
    if (phase) begin
      if (state == RESYNC) begin
        if (origin && head_sof) begin
          pop      = 1'b1;
          goto_run = 1'b1;
          rgb_nxt  = rgb_t'(pix_data);
        end else begin
          // Drain stale pixels; a sof head is held until the frame origin.
          pop = pix_valid & ~pix_sof;
        end
      end else if (active) begin
        if (origin && !head_sof) begin
          // Frame lost alignment: keep the head for the resync search.
          goto_resync = 1'b1;
        end else if (!pix_valid) begin
          uf_event = 1'b1;
        end else begin
          pop = 1'b1;
          if (pix_sof && !origin) begin
            goto_resync = 1'b1;
          end else begin
            rgb_nxt = rgb_t'(pix_data);
          end
        end
      end
    end
  end

  assign pix_ready = pop & reset_reset_n;

  // Stream FSM and registered DAC outputs, all updated on the advance cycle.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state       <= RESYNC;
      rgb_q       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank   <= 1'b0;
      frame_start <= 1'b0;
    end else if (phase) begin
      if (goto_run) begin
        state <= RUN;
      end else if (goto_resync) begin
        state <= RESYNC;
      end
      rgb_q       <= rgb_nxt;
      vga_hs      <= hs_n;
      vga_vs      <= vs_n;
      vga_blank   <= active;
      frame_start <= origin;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Sticky underflow flag and saturating counter; clear wins over a new event.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (err_clr) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (uf_event) begin
      underflow     <= 1'b1;
      underflow_cnt <= sat_inc(underflow_cnt, CNT_MAX);
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_sync    = 1'b0;
  assign vga_vga_clk = phase;
  assign dbg_state   = state;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout using a reduced raster so whole
// frames fit in a short run.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam logic [23:0] FILL = 24'hFF00FF;
  localparam int CNT_MAX = 20;
  localparam logic [23:0] PIX00 = 24'h00005A;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid, pix_ready, err_clr;
  logic        underflow, frame_start;
  logic [15:0] underflow_cnt;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank, vga_sync, vga_vga_clk;
  scan_state_t dbg_state;

  always #5 clk_clk = ~clk_clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FILL_RGB(FILL), .CNT_MAX(16'(CNT_MAX))
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_clr(err_clr), .underflow(underflow), .underflow_cnt(underflow_cnt),
    .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_sync(vga_sync),
    .vga_vga_clk(vga_vga_clk), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slot position comes from a linear slot index since reset; colours and
  // stream consumption follow the display rules directly.
  bit          m_phase, m_run, m_ready, m_uf_ev, m_uf, m_hs, m_vs, m_blank, m_fs;
  int          m_k, m_cnt;
  logic [23:0] m_rgb;

  task automatic model_step(input bit v, input bit sof, input logic [23:0] d,
                            input bit clr, input bit rn);
    int h, ln;
    bit act, org;
    m_ready = 1'b0;
    m_uf_ev = 1'b0;
    if (!rn) begin
      m_phase = 0; m_k = 0; m_run = 0; m_rgb = '0; m_hs = 1; m_vs = 1;
      m_blank = 0; m_fs = 0; m_uf = 0; m_cnt = 0;
      return;
    end
    if (m_phase) begin
      h   = m_k % HT;
      ln  = m_k / HT;
      act = (h < HA) && (ln < VA);
      org = (m_k == 0);
      m_hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
      m_vs    = !((ln >= VA + VFP) && (ln < VA + VFP + VS));
      m_blank = act;
      m_fs    = org;
      m_rgb   = act ? FILL : 24'h0;
      if (!m_run) begin
        if (org && v && sof) begin
          m_ready = 1; m_run = 1; m_rgb = d;
        end else begin
          m_ready = v && !sof;
        end
      end else if (act) begin
        if (org && !(v && sof)) m_run = 0;
        else if (!v) m_uf_ev = 1;
        else begin
          m_ready = 1;
          if (sof && !org) m_run = 0;
          else m_rgb = d;
        end
      end
      m_k = (m_k + 1) % (HT * VT);
    end else begin
      m_fs = 0;
    end
    if (clr) begin
      m_uf = 0; m_cnt = 0;
    end else if (m_uf_ev) begin
      m_uf = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    m_phase = !m_phase;
  endtask

  // ---------------- stream source and driver ----------------
  int src_idx;
  int drop_left = 0;
  bit rand_valid = 0, rand_clr = 0, clr_req = 0, clr_hold = 0, rst_req = 0;
  bit stray_en = 0;
  int stray_idx = 0;

  bit meas_on = 0;
  int meas_pops, meas_hs_low, meas_vs_low, meas_fs, hs_cur, vs_cur, hs_run, vs_run;

  function automatic logic [23:0] src_pixel(input int idx);
    logic [7:0] h8, v8;
    h8 = 8'(idx % HA);
    v8 = 8'(idx / HA);
    return {h8, v8, 8'h5A};
  endfunction

  task automatic cycle();
    bit v, sof, clr, rn, popped;
    logic [23:0] d;
    v = 1'b1;
    if (drop_left > 0) v = 1'b0;
    else if (rand_valid) v = ($urandom_range(0, 99) < 85);
    d   = src_pixel(src_idx);
    sof = (src_idx == 0) || (stray_en && src_idx == stray_idx);
    clr = clr_req || clr_hold || (rand_clr && $urandom_range(0, 63) == 0);
    clr_req = 0;
    rn = !rst_req;
    rst_req = 0;
    pix_valid = v; pix_sof = sof; pix_data = d; err_clr = clr; reset_reset_n = rn;
    #1;
    model_step(v, sof, d, clr, rn);
    check("pix_ready", 64'(pix_ready), 64'(m_ready));
    popped = v && (pix_ready === 1'b1);
    if (m_uf_ev && drop_left > 0) drop_left--;
    @(posedge clk_clk);
    #1;
    if (popped) begin
      if (stray_en && src_idx == stray_idx) stray_en = 0;
      src_idx = (src_idx + 1) % NPIX;
    end
    check("outputs",
          64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_sync, vga_vga_clk,
               frame_start, underflow, underflow_cnt}),
          64'({m_rgb, m_hs, m_vs, m_blank, 1'b0, m_phase, m_fs, m_uf, 16'(m_cnt)}));
    check("state", 64'(dbg_state == RUN), 64'(m_run));
    if (meas_on) begin
      if (popped) meas_pops++;
      if (!vga_hs) begin meas_hs_low++; hs_cur++; end
      else begin if (hs_cur > 0) hs_run = hs_cur; hs_cur = 0; end
      if (!vga_vs) begin meas_vs_low++; vs_cur++; end
      else begin if (vs_cur > 0) vs_run = vs_cur; vs_cur = 0; end
      if (frame_start) meas_fs++;
    end
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FRAME_CLK + 4 && !seen; i++) begin
      cycle();
      if (frame_start === 1'b1) seen = 1;
    end
    check("wait_frame_start", 64'(seen), 64'd1);
  endtask

  task automatic run_drop(input int n);
    drop_left = n;
    for (int i = 0; i < 4 * FRAME_CLK && drop_left > 0; i++) cycle();
    check("drop_timeout", 64'(drop_left), 64'd0);
    drop_left = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check(tag,
          64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_sync, vga_vga_clk,
               frame_start, underflow, underflow_cnt, pix_ready}),
          64'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0}));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_reset_n = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b0; pix_data = '0; err_clr = 1'b0;
    src_idx = $urandom_range(1, NPIX - 1);

    repeat (3) begin rst_req = 1; cycle(); end
    check_reset_values("reset_values");

    // Reset release with a stream that starts mid-frame.
    wait_fs();
    check("first_fs_fill", 64'({vga_r, vga_g, vga_b}), 64'(FILL));
    wait_fs();
    check("first_pixel", 64'({vga_r, vga_g, vga_b}), 64'(PIX00));

    // Continuous stream over one full frame period.
    meas_pops = 0; meas_hs_low = 0; meas_vs_low = 0; meas_fs = 0;
    hs_cur = 0; vs_cur = 0; hs_run = 0; vs_run = 0;
    meas_on = 1;
    repeat (FRAME_CLK) cycle();
    meas_on = 0;
    check("pops_per_frame", 64'(meas_pops), 64'(NPIX));
    check("hs_low_total", 64'(meas_hs_low), 64'(2 * HS * VT));
    check("vs_low_total", 64'(meas_vs_low), 64'(2 * VS * HT));
    check("hs_pulse_len", 64'(hs_run), 64'(2 * HS));
    check("vs_pulse_len", 64'(vs_run), 64'(2 * VS * HT));
    check("fs_per_frame", 64'(meas_fs), 64'd1);
    check("clean_underflow", 64'({underflow, underflow_cnt}), 64'd0);

    // Ten consecutive underflowed active slots, then a clear.
    repeat (6) cycle();
    run_drop(10);
    check("uf_flag", 64'(underflow), 64'd1);
    check("uf_count10", 64'(underflow_cnt), 64'd10);
    clr_req = 1;
    cycle();
    check("uf_cleared", 64'({underflow, underflow_cnt}), 64'd0);

    // Saturation, then clear colliding with every underflow.
    wait_fs(); wait_fs();
    repeat (2) cycle();
    run_drop(CNT_MAX + 3);
    check("uf_saturate", 64'(underflow_cnt), 64'(CNT_MAX));
    clr_hold = 1;
    run_drop(3);
    clr_hold = 0;
    check("clr_beats_uf", 64'({underflow, underflow_cnt}), 64'd0);

    // Stray sof inside the frame.
    wait_fs(); wait_fs();
    check("recovered_pixel", 64'({vga_r, vga_g, vga_b}), 64'(PIX00));
    stray_idx = 2 * HA + 3;
    stray_en = 1;
    for (int i = 0; i < 2 * FRAME_CLK && stray_en; i++) cycle();
    check("stray_consumed", 64'(stray_en), 64'd0);
    check("stray_fill", 64'({vga_r, vga_g, vga_b}), 64'(FILL));
    check("stray_resync", 64'(dbg_state == RUN), 64'd0);
    wait_fs();
    check("stray_nocount", 64'(underflow_cnt), 64'd0);
    check("stray_recover", 64'({vga_r, vga_g, vga_b}), 64'(PIX00));

    // One-cycle reset in the middle of a line with errors pending.
    repeat (4) cycle();
    run_drop(2);
    repeat (2 * HT) cycle();
    check("pre_reset_cnt", 64'(underflow_cnt), 64'd2);
    rst_req = 1;
    cycle();
    check_reset_values("midline_reset");
    wait_fs();
    check("reset_fs_fill", 64'({vga_r, vga_g, vga_b}), 64'(FILL));
    wait_fs();
    check("reset_recover", 64'({vga_r, vga_g, vga_b}), 64'(PIX00));

    // Random valid gaps and occasional clears against the model.
    rand_valid = 1; rand_clr = 1;
    repeat (6 * FRAME_CLK) cycle();
    rand_valid = 0; rand_clr = 0;
    repeat (2 * FRAME_CLK) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
